// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared defaults and helpers for the 7-segment scan controller.
package seg7_scan_ctrl_pkg;

    localparam int unsigned DefNumDigits  = 4;
    localparam int unsigned DefRefreshDiv = 100000;

    // Width of the digit index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display-side bundle: hex word and controls in, scan outputs back out.
interface seg7_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] x;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic                    blank;
    logic [3:0]              digit;
    logic [NUM_DIGITS-1:0]   an;
    logic                    dp;
    logic                    frame_tick;

    modport master (
        output x, dp_mask, blank,
        input  digit, an, dp, frame_tick
    );

    modport slave (
        input  x, dp_mask, blank,
        output digit, an, dp, frame_tick
    );
endinterface

// File: rtl/seg7_refresh_div.sv
// Digit-slot prescaler: slot_tick is high on the last of every REFRESH_DIV cycles.
module seg7_refresh_div #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic clr,
    output logic slot_tick
);
    localparam int unsigned CntW = $clog2(REFRESH_DIV);

    logic [CntW-1:0] cnt_q;

    assign slot_tick = (cnt_q == CntW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (slot_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multi-digit common-anode scan controller with per-frame snapshot of the hex word.
// Define SEG7_LZ_BLANK_EN to blank digits above the most-significant nonzero nibble.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = DefNumDigits,
    parameter int unsigned REFRESH_DIV = DefRefreshDiv
) (
    input  logic            clk,
    input  logic            clr,
    seg7_scan_ctrl_if.slave bus
);
    localparam int unsigned IdxW = idx_width(NUM_DIGITS);

    logic                    slot_tick;
    logic                    wrap;
    logic                    load_pend_q;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [3:0]              nib_sel;
    logic                    dp_sel;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic                    lit;

    seg7_refresh_div #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_div (
        .clk       (clk),
        .clr       (clr),
        .slot_tick (slot_tick)
    );

    always_comb begin
        wrap  = slot_tick && (idx_q == IdxW'(NUM_DIGITS - 1));
        idx_d = idx_q;
        if (slot_tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end

        // Loading on the wrap edge lets digit 0 of the new frame see the new word.
        shadow_d = shadow_q;
        dp_sh_d  = dp_sh_q;
        if (load_pend_q || wrap) begin
            shadow_d = bus.x;
            dp_sh_d  = bus.dp_mask;
        end

        nib_sel = 4'h0;
        dp_sel  = 1'b0;
        an_sel  = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IdxW'(i)) begin
                nib_sel   = shadow_d[4*i +: 4];
                dp_sel    = dp_sh_d[i];
                an_sel[i] = 1'b0;
            end
        end

`ifdef SEG7_LZ_BLANK_EN
        lit = 1'b1;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            if ((shadow_d[4*NUM_DIGITS-1:4*i] == '0) && (idx_d == IdxW'(i))) begin
                lit = 1'b0;
            end
        end
`else
        lit = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            idx_q          <= '0;
            shadow_q       <= '0;
            dp_sh_q        <= '0;
            load_pend_q    <= 1'b1;
            bus.an         <= '1;
            bus.digit      <= 4'h0;
            bus.dp         <= 1'b1;
            bus.frame_tick <= 1'b0;
        end else begin
            idx_q          <= idx_d;
            shadow_q       <= shadow_d;
            dp_sh_q        <= dp_sh_d;
            load_pend_q    <= 1'b0;
            bus.frame_tick <= wrap;
            bus.digit      <= nib_sel;
            bus.an         <= (bus.blank || !lit) ? '1 : an_sel;
            bus.dp         <= (bus.blank || !lit) ? 1'b1 : ~dp_sel;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed-vector bench for seg7_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=4).
module tb_seg7_scan_ctrl;

    typedef struct {
        int unsigned at;
        logic [15:0] x;
        logic [3:0]  dpm;
        logic        blank;
        logic [3:0]  an;
        logic [3:0]  dig;
        logic        dp;
        logic        ft;
        logic [3:0]  an_lz;
        logic        dp_lz;
    } vec_t;

    logic clk;
    logic clr;
    int   n_cmp;
    int   n_bad;
    int unsigned e;
    vec_t tbl[$];

    seg7_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    initial begin
        vec_t v;
        int   found;
        n_cmp = 0;
        n_bad = 0;
        e     = 0;

        //             at  x         dpm      blk   an       dig    dp    ft    an_lz    dp_lz
        tbl.push_back(vec_t'{ 1, 16'h1A2F, 4'b0000, 1'b0, 4'b1110, 4'hF, 1'b1, 1'b0, 4'b1110, 1'b1});
        tbl.push_back(vec_t'{ 3, 16'h1A2F, 4'b0000, 1'b0, 4'b1110, 4'hF, 1'b1, 1'b0, 4'b1110, 1'b1});
        tbl.push_back(vec_t'{ 4, 16'h1A2F, 4'b0000, 1'b0, 4'b1101, 4'h2, 1'b1, 1'b0, 4'b1101, 1'b1});
        tbl.push_back(vec_t'{ 8, 16'h1A2F, 4'b0000, 1'b0, 4'b1011, 4'hA, 1'b1, 1'b0, 4'b1011, 1'b1});
        tbl.push_back(vec_t'{12, 16'h1A2F, 4'b0000, 1'b0, 4'b0111, 4'h1, 1'b1, 1'b0, 4'b0111, 1'b1});
        tbl.push_back(vec_t'{15, 16'h1A2F, 4'b0000, 1'b0, 4'b0111, 4'h1, 1'b1, 1'b0, 4'b0111, 1'b1});
        tbl.push_back(vec_t'{16, 16'h1A2F, 4'b0000, 1'b0, 4'b1110, 4'hF, 1'b1, 1'b1, 4'b1110, 1'b1});
        tbl.push_back(vec_t'{17, 16'h1A2F, 4'b0000, 1'b0, 4'b1110, 4'hF, 1'b1, 1'b0, 4'b1110, 1'b1});
        tbl.push_back(vec_t'{21, 16'h1A2F, 4'b0000, 1'b0, 4'b1101, 4'h2, 1'b1, 1'b0, 4'b1101, 1'b1});
        // x changes mid-slot 1: rest of this frame must keep the old word
        tbl.push_back(vec_t'{22, 16'h0000, 4'b0000, 1'b0, 4'b1101, 4'h2, 1'b1, 1'b0, 4'b1101, 1'b1});
        tbl.push_back(vec_t'{24, 16'h0000, 4'b0000, 1'b0, 4'b1011, 4'hA, 1'b1, 1'b0, 4'b1011, 1'b1});
        tbl.push_back(vec_t'{28, 16'h0000, 4'b0000, 1'b0, 4'b0111, 4'h1, 1'b1, 1'b0, 4'b0111, 1'b1});
        tbl.push_back(vec_t'{32, 16'h0000, 4'b0100, 1'b0, 4'b1110, 4'h0, 1'b1, 1'b1, 4'b1110, 1'b1});
        tbl.push_back(vec_t'{36, 16'h0000, 4'b0100, 1'b0, 4'b1101, 4'h0, 1'b1, 1'b0, 4'b1111, 1'b1});
        tbl.push_back(vec_t'{40, 16'h0000, 4'b0100, 1'b0, 4'b1011, 4'h0, 1'b0, 1'b0, 4'b1111, 1'b1});
        tbl.push_back(vec_t'{44, 16'h0000, 4'b0100, 1'b0, 4'b0111, 4'h0, 1'b1, 1'b0, 4'b1111, 1'b1});
        tbl.push_back(vec_t'{45, 16'h0050, 4'b0100, 1'b0, 4'b0111, 4'h0, 1'b1, 1'b0, 4'b1111, 1'b1});
        tbl.push_back(vec_t'{48, 16'h0050, 4'b0100, 1'b0, 4'b1110, 4'h0, 1'b1, 1'b1, 4'b1110, 1'b1});
        tbl.push_back(vec_t'{52, 16'h0050, 4'b0100, 1'b0, 4'b1101, 4'h5, 1'b1, 1'b0, 4'b1101, 1'b1});
        tbl.push_back(vec_t'{56, 16'h0050, 4'b0100, 1'b0, 4'b1011, 4'h0, 1'b0, 1'b0, 4'b1111, 1'b1});
        tbl.push_back(vec_t'{57, 16'h0050, 4'b0100, 1'b1, 4'b1111, 4'h0, 1'b1, 1'b0, 4'b1111, 1'b1});
        tbl.push_back(vec_t'{60, 16'h0050, 4'b0100, 1'b1, 4'b1111, 4'h0, 1'b1, 1'b0, 4'b1111, 1'b1});
        tbl.push_back(vec_t'{64, 16'h0050, 4'b0100, 1'b1, 4'b1111, 4'h0, 1'b1, 1'b1, 4'b1111, 1'b1});
        tbl.push_back(vec_t'{65, 16'h0050, 4'b0100, 1'b0, 4'b1110, 4'h0, 1'b1, 1'b0, 4'b1110, 1'b1});
        tbl.push_back(vec_t'{68, 16'h0050, 4'b0100, 1'b0, 4'b1101, 4'h5, 1'b1, 1'b0, 4'b1101, 1'b1});
        tbl.push_back(vec_t'{72, 16'h0050, 4'b0100, 1'b0, 4'b1011, 4'h0, 1'b0, 1'b0, 4'b1111, 1'b1});

        // Reset for three cycles
        clr         = 1'b0;
        bus.x       = 16'h1A2F;
        bus.dp_mask = 4'b0000;
        bus.blank   = 1'b0;
        #1 clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_an", 32'(bus.an), 32'h F);
        chk("reset_dp", 32'(bus.dp), 32'h1);
        chk("reset_digit", 32'(bus.digit), 32'h0);
        chk("reset_ft", 32'(bus.frame_tick), 32'h0);
        clr = 1'b0;

        foreach (tbl[i]) begin
            v           = tbl[i];
            bus.x       = v.x;
            bus.dp_mask = v.dpm;
            bus.blank   = v.blank;
            while (e < v.at) tick();
`ifdef SEG7_LZ_BLANK_EN
            chk($sformatf("an[e=%0d]", v.at), 32'(bus.an), 32'(v.an_lz));
            chk($sformatf("dp[e=%0d]", v.at), 32'(bus.dp), 32'(v.dp_lz));
`else
            chk($sformatf("an[e=%0d]", v.at), 32'(bus.an), 32'(v.an));
            chk($sformatf("dp[e=%0d]", v.at), 32'(bus.dp), 32'(v.dp));
`endif
            chk($sformatf("digit[e=%0d]", v.at), 32'(bus.digit), 32'(v.dig));
            chk($sformatf("ft[e=%0d]", v.at), 32'(bus.frame_tick), 32'(v.ft));
        end

        // Asynchronous clear mid-frame blanks anodes before the next edge
        tick();
        #2 clr = 1'b1;
        #1;
        chk("async_clr_an", 32'(bus.an), 32'hF);
        chk("async_clr_dp", 32'(bus.dp), 32'h1);
        chk("async_clr_digit", 32'(bus.digit), 32'h0);
        bus.x       = 16'h1234;
        bus.dp_mask = 4'b0001;
        @(posedge clk);
        #1;
        clr = 1'b0;
        e   = 0;
        tick();
        chk("post_clr_an", 32'(bus.an), 32'hE);
        chk("post_clr_digit", 32'(bus.digit), 32'h4);
        chk("post_clr_dp", 32'(bus.dp), 32'h0);

        // First wrap after release is 16 edges in
        found = 0;
        while (!found && e < 40) begin
            tick();
            if (bus.frame_tick) found = 1;
        end
        chk("first_wrap_edge", found ? 32'(e) : 32'hFFFF, 32'd16);
        chk("first_wrap_an", 32'(bus.an), 32'hE);
        chk("first_wrap_digit", 32'(bus.digit), 32'h4);
        tick();
        chk("wrap_pulse_width", 32'(bus.frame_tick), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
